// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: access sizes, data-memory FSM states,
// and size-to-byte-enable / misalignment helpers reused by bus blocks.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE       = 3'd0,
        HWORD      = 3'd1,
        WORD       = 3'd2,
        DWORD      = 3'd3,
        UNDEF_SIZE = 3'd7
    } biu_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dmem_state_t;

    // Byte enables for a 64-bit lane set; 32-bit users take the low nibble.
    function automatic logic [7:0] biu_be(
        input biu_size_t  size,
        input logic [2:0] a,
        input logic       is64
    );
        logic [2:0] o;
        logic [7:0] be;
        o  = is64 ? a : {1'b0, a[1:0]};
        be = 8'h00;
        case (size)
            BYTE:    be = 8'h01 << o;
            HWORD:   be = 8'h03 << o;
            WORD:    be = is64 ? (8'h0F << o) : 8'h0F;
            DWORD:   be = is64 ? 8'hFF : 8'h00;
            default: be = 8'h00;
        endcase
        return be;
    endfunction

    function automatic logic biu_misaligned(
        input biu_size_t  size,
        input logic [2:0] a,
        input logic       is64
    );
        logic mis;
        mis = 1'b1;
        case (size)
            BYTE:    mis = 1'b0;
            HWORD:   mis = a[0];
            WORD:    mis = |a[1:0];
            DWORD:   mis = is64 ? |a : 1'b1;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_dmem_fifo.sv
// In-order request buffer for the data-memory response block.
module riscv_dmem_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= inc(wr_q);
            if (do_pop)  rd_q <= inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory request buffer and backend sequencer: queues core accesses,
// issues aligned ones to the backend and returns one in-order ack each.
module riscv_dmem_resp
    import biu_constants_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  biu_size_t         dmem_size,
    input  logic [XLEN-1:0]   dmem_adr,
    input  logic [XLEN-1:0]   dmem_d,
    output logic              dmem_busy,
    output logic              dmem_ack,
    output logic [XLEN-1:0]   dmem_q,
    output logic              dmem_misaligned,
    output logic              dmem_page_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_adr,
    output logic [XLEN-1:0]   mem_d,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_q,
    input  logic              mem_err
);

    localparam int   NB   = XLEN / 8;
    localparam logic IS64 = (XLEN == 64);

    typedef struct packed {
        logic            we;
        biu_size_t       size;
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] d;
        logic            mis;
    } entry_t;

    entry_t      in_e, head;
    logic        push, pop, full, empty;
    logic [7:0]  be8;
    dmem_state_t state_q;

    logic            dmem_ack_q, dmem_mis_q, dmem_pf_q;
    logic [XLEN-1:0] dmem_q_q;
    logic            mem_req_q, mem_we_q;
    logic [XLEN-1:0] mem_adr_q, mem_d_q;
    logic [NB-1:0]   mem_be_q;

    always_comb begin
        in_e      = '0;
        in_e.we   = dmem_we;
        in_e.size = dmem_size;
        in_e.adr  = dmem_adr;
        in_e.d    = dmem_d;
        in_e.mis  = biu_misaligned(dmem_size, dmem_adr[2:0], IS64);
    end

    assign push = dmem_req && !full;
    assign be8  = biu_be(head.size, head.adr[2:0], IS64);

    // The head leaves the buffer on the edge that registers its response.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ISSUE:   pop = mem_ack;
            default: pop = !empty && head.mis;
        endcase
    end

    riscv_dmem_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_e),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dmem_ack_q <= 1'b0;
            dmem_mis_q <= 1'b0;
            dmem_pf_q  <= 1'b0;
            dmem_q_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_d_q    <= '0;
            mem_be_q   <= '0;
        end else begin
            dmem_ack_q <= 1'b0;
            case (state_q)
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        dmem_ack_q <= 1'b1;
                        dmem_mis_q <= 1'b0;
                        dmem_pf_q  <= mem_err;
                        dmem_q_q   <= (mem_we_q || mem_err) ? '0 : mem_q;
                        state_q    <= RESP;
                    end
                end
                default: begin
                    if (empty) begin
                        state_q <= IDLE;
                    end else if (head.mis) begin
                        dmem_ack_q <= 1'b1;
                        dmem_mis_q <= 1'b1;
                        dmem_pf_q  <= 1'b0;
                        dmem_q_q   <= '0;
                        state_q    <= RESP;
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= head.we;
                        mem_adr_q <= head.adr & ~XLEN'(NB - 1);
                        mem_be_q  <= NB'(be8);
                        mem_d_q   <= head.d;
                        state_q   <= ISSUE;
                    end
                end
            endcase
        end
    end

    assign dmem_busy       = full;
    assign dmem_ack        = dmem_ack_q;
    assign dmem_q          = dmem_q_q;
    assign dmem_misaligned = dmem_mis_q;
    assign dmem_page_fault = dmem_pf_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_adr         = mem_adr_q;
    assign mem_d           = mem_d_q;
    assign mem_be          = mem_be_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Directed bench for riscv_dmem_resp (XLEN=32, DEPTH=2).
module tb_riscv_dmem_resp;
    import biu_constants_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_req, dmem_we;
    biu_size_t   dmem_size;
    logic [31:0] dmem_adr, dmem_d;
    logic        dmem_busy, dmem_ack, dmem_misaligned, dmem_page_fault;
    logic [31:0] dmem_q;
    logic        mem_req, mem_we;
    logic [31:0] mem_adr, mem_d;
    logic [3:0]  mem_be;
    logic        mem_ack, mem_err;
    logic [31:0] mem_q;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    riscv_dmem_resp #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_size       (dmem_size),
        .dmem_adr        (dmem_adr),
        .dmem_d          (dmem_d),
        .dmem_busy       (dmem_busy),
        .dmem_ack        (dmem_ack),
        .dmem_q          (dmem_q),
        .dmem_misaligned (dmem_misaligned),
        .dmem_page_fault (dmem_page_fault),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_adr         (mem_adr),
        .mem_d           (mem_d),
        .mem_be          (mem_be),
        .mem_ack         (mem_ack),
        .mem_q           (mem_q),
        .mem_err         (mem_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input biu_size_t sz,
                         input logic [31:0] a, input logic [31:0] d);
        dmem_req  = 1'b1;
        dmem_we   = we;
        dmem_size = sz;
        dmem_adr  = a;
        dmem_d    = d;
    endtask

    task automatic send(input logic we, input biu_size_t sz,
                        input logic [31:0] a, input logic [31:0] d);
        drive(we, sz, a, d);
        tick();
        dmem_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({dmem_busy, dmem_ack, dmem_misaligned, dmem_page_fault, mem_req, mem_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags got %b want 000000",
                {dmem_busy, dmem_ack, dmem_misaligned, dmem_page_fault, mem_req, mem_we});
        end
        checks++;
        if (dmem_q !== 32'h0) begin
            fails++; $display("FAIL reset_dmem_q got %h want 0", dmem_q);
        end
        checks++;
        if (mem_adr !== 32'h0) begin
            fails++; $display("FAIL reset_mem_adr got %h want 0", mem_adr);
        end
        checks++;
        if (mem_be !== 4'h0) begin
            fails++; $display("FAIL reset_mem_be got %h want 0", mem_be);
        end
        checks++;
        if (mem_d !== 32'h0) begin
            fails++; $display("FAIL reset_mem_d got %h want 0", mem_d);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        send(1'b0, WORD, 32'h104, 32'h0);
        checks++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL load_accept_cycle mem_req got %b want 0", mem_req);
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_adr, mem_be} !== {1'b1, 1'b0, 32'h104, 4'hF}) begin
            fails++;
            $display("FAIL load_issue req=%b we=%b adr=%h be=%h want 1 0 00000104 f",
                mem_req, mem_we, mem_adr, mem_be);
        end
        tick();
        tick();
        checks++;
        if ({mem_req, mem_adr, dmem_ack} !== {1'b1, 32'h104, 1'b0}) begin
            fails++;
            $display("FAIL load_hold req=%b adr=%h ack=%b want 1 00000104 0",
                mem_req, mem_adr, dmem_ack);
        end
        mem_ack = 1'b1;
        mem_q   = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        mem_q   = 32'h0;
        checks++;
        if ({dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
            fails++;
            $display("FAIL load_resp ack=%b q=%h mis=%b pf=%b want 1 deadbeef 0 0",
                dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL load_req_drop got %b want 0", mem_req);
        end
        tick();
        checks++;
        if (dmem_ack !== 1'b0) begin
            fails++; $display("FAIL load_ack_pulse got %b want 0", dmem_ack);
        end
    endtask

    task automatic test_store_byte();
        send(1'b1, BYTE, 32'h203, 32'hAA000000);
        tick();
        checks++;
        if ({mem_req, mem_we, mem_be, mem_adr, mem_d} !==
            {1'b1, 1'b1, 4'b1000, 32'h200, 32'hAA000000}) begin
            fails++;
            $display("FAIL sb_issue req=%b we=%b be=%b adr=%h d=%h want 1 1 1000 00000200 aa000000",
                mem_req, mem_we, mem_be, mem_adr, mem_d);
        end
        mem_ack = 1'b1;
        mem_q   = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        mem_q   = 32'h0;
        checks++;
        if ({dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault} !== {1'b1, 32'h0, 2'b00}) begin
            fails++;
            $display("FAIL sb_resp ack=%b q=%h mis=%b pf=%b want 1 00000000 0 0",
                dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault);
        end
        tick();
    endtask

    task automatic test_byte_enables();
        biu_size_t   sz [5] = '{BYTE, BYTE, HWORD, HWORD, WORD};
        logic [31:0] ad [5] = '{32'h100, 32'h102, 32'h102, 32'h100, 32'h10B - 32'h3};
        logic [3:0]  be [5] = '{4'h1, 4'h4, 4'hC, 4'h3, 4'hF};
        logic [31:0] al [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h108};
        for (int i = 0; i < 5; i++) begin
            send(1'b0, sz[i], ad[i], 32'h0);
            tick();
            checks++;
            if ({mem_req, mem_be, mem_adr} !== {1'b1, be[i], al[i]}) begin
                fails++;
                $display("FAIL be_table[%0d] req=%b be=%h adr=%h want 1 %h %h",
                    i, mem_req, mem_be, mem_adr, be[i], al[i]);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            tick();
        end
    endtask

    task automatic test_misaligned();
        biu_size_t   sz [4] = '{HWORD, WORD, DWORD, UNDEF_SIZE};
        logic [31:0] ad [4] = '{32'h101, 32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            send(1'b0, sz[i], ad[i], 32'h0);
            checks++;
            if ({dmem_ack, mem_req} !== 2'b00) begin
                fails++;
                $display("FAIL mis_head[%0d] ack=%b req=%b want 0 0", i, dmem_ack, mem_req);
            end
            tick();
            checks++;
            if ({dmem_ack, dmem_misaligned, mem_req, dmem_page_fault, dmem_q} !==
                {4'b1100, 32'h0}) begin
                fails++;
                $display("FAIL mis_resp[%0d] ack=%b mis=%b req=%b pf=%b q=%h want 1 1 0 0 0",
                    i, dmem_ack, dmem_misaligned, mem_req, dmem_page_fault, dmem_q);
            end
            tick();
            checks++;
            if ({dmem_ack, mem_req} !== 2'b00) begin
                fails++;
                $display("FAIL mis_after[%0d] ack=%b req=%b want 0 0", i, dmem_ack, mem_req);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [4];
        int n;
        n = 0;
        drive(1'b0, WORD, 32'h10, 32'h0);
        tick();
        drive(1'b0, WORD, 32'h14, 32'h0);
        tick();
        checks++;
        if (dmem_busy !== 1'b1) begin
            fails++; $display("FAIL b2b_busy got %b want 1", dmem_busy);
        end
        drive(1'b0, WORD, 32'h18, 32'h0);
        tick();
        dmem_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({dmem_busy, mem_req, mem_adr, dmem_ack} !== {1'b1, 1'b1, 32'h10, 1'b0}) begin
            fails++;
            $display("FAIL b2b_wait busy=%b req=%b adr=%h ack=%b want 1 1 00000010 0",
                dmem_busy, mem_req, mem_adr, dmem_ack);
        end
        mem_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mem_q = 32'hC0DE0000 | mem_adr;
            tick();
            if (dmem_ack === 1'b1) begin
                if (n < 4) got[n] = dmem_q;
                n++;
            end
        end
        mem_ack = 1'b0;
        mem_q   = 32'h0;
        checks++;
        if (n !== 2) begin
            fails++; $display("FAIL b2b_ack_count got %0d want 2", n);
        end
        checks++;
        if (n < 1 || got[0] !== 32'hC0DE0010) begin
            fails++; $display("FAIL b2b_first got %h want c0de0010", (n < 1) ? 32'h0 : got[0]);
        end
        checks++;
        if (n < 2 || got[1] !== 32'hC0DE0014) begin
            fails++; $display("FAIL b2b_second got %h want c0de0014", (n < 2) ? 32'h0 : got[1]);
        end
        checks++;
        if ({dmem_busy, mem_req} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_drained busy=%b req=%b want 0 0", dmem_busy, mem_req);
        end
    endtask

    task automatic test_fault();
        send(1'b0, WORD, 32'h300, 32'h0);
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL fault_issue got %b want 1", mem_req);
        end
        mem_ack = 1'b1;
        mem_err = 1'b1;
        mem_q   = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        mem_q   = 32'h0;
        checks++;
        if ({dmem_ack, dmem_page_fault, dmem_misaligned, dmem_q} !== {3'b110, 32'h0}) begin
            fails++;
            $display("FAIL fault_resp ack=%b pf=%b mis=%b q=%h want 1 1 0 00000000",
                dmem_ack, dmem_page_fault, dmem_misaligned, dmem_q);
        end
        tick();
    endtask

    task automatic test_reset_issue();
        drive(1'b0, WORD, 32'h400, 32'h0);
        tick();
        drive(1'b0, WORD, 32'h404, 32'h0);
        tick();
        dmem_req = 1'b0;
        checks++;
        if ({mem_req, dmem_busy} !== 2'b11) begin
            fails++;
            $display("FAIL rsti_pre req=%b busy=%b want 1 1", mem_req, dmem_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req, dmem_busy, dmem_ack} !== 3'b000) begin
            fails++;
            $display("FAIL rsti_abort req=%b busy=%b ack=%b want 0 0 0",
                mem_req, dmem_busy, dmem_ack);
        end
        mem_ack = 1'b1;
        mem_q   = 32'h1234;
        tick();
        mem_ack = 1'b0;
        mem_q   = 32'h0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({dmem_ack, mem_req, dmem_busy} !== 3'b000) begin
                fails++;
                $display("FAIL rsti_quiet[%0d] ack=%b req=%b busy=%b want 0 0 0",
                    c, dmem_ack, mem_req, dmem_busy);
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_size = BYTE;
        dmem_adr  = 32'h0;
        dmem_d    = 32'h0;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_q     = 32'h0;
        test_reset();
        test_load();
        test_store_byte();
        test_byte_enables();
        test_misaligned();
        test_back_to_back();
        test_fault();
        test_reset_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached before end of test");
        $fatal(1);
    end

endmodule
